// File: rtl/prio_encoder_arb_v.sv
// Registered N-line priority encoder with fixed/round-robin arbitration and a valid/ready grant.
// Optional HOLD timeout enabled by defining PRIO_ENC_TIMEOUT_EN.
module prio_encoder_arb_v #(
  parameter int N_REQ = 8,
  parameter int TIMEOUT = 15,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_rr_en,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_code,
  output logic [N_REQ-1:0] o_onehot,
  output logic             o_valid,
  output logic             o_multi,
  output logic             o_timeout
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] code_nxt;
  logic [N_REQ-1:0] onehot_nxt;
  logic             valid_nxt;
  logic             multi_nxt;

  logic [IDX_W-1:0] fix_win;
  logic [IDX_W-1:0] rr_win;
  logic             rr_hit;
  logic [IDX_W-1:0] sel;
  logic             multi_c;

`ifdef PRIO_ENC_TIMEOUT_EN
  logic [7:0] cnt, cnt_nxt;
  logic       to_nxt;
`endif

  always_comb begin
    fix_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) fix_win = IDX_W'(k);
    end
  end

  // Search starts one past the last grant and wraps at N_REQ-1.
  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!rr_hit && i_req[(int'(ptr) + i) % N_REQ]) begin
        rr_hit = 1'b1;
        rr_win = IDX_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign sel     = i_rr_en ? rr_win : fix_win;
  assign multi_c = |(i_req & (i_req - N_REQ'(1)));

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    code_nxt   = o_code;
    onehot_nxt = o_onehot;
    valid_nxt  = o_valid;
    multi_nxt  = o_multi;
`ifdef PRIO_ENC_TIMEOUT_EN
    cnt_nxt    = cnt;
    to_nxt     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (|i_req) begin
          state_nxt  = HOLD;
          code_nxt   = sel;
          onehot_nxt = N_REQ'(1) << sel;
          valid_nxt  = 1'b1;
          multi_nxt  = multi_c;
`ifdef PRIO_ENC_TIMEOUT_EN
          cnt_nxt    = '0;
`endif
        end else begin
          code_nxt   = '0;
          onehot_nxt = '0;
          valid_nxt  = 1'b0;
          multi_nxt  = 1'b0;
        end
      end
      HOLD: begin
        if (i_ready) begin
          state_nxt  = IDLE;
          ptr_nxt    = o_code;
          onehot_nxt = '0;
          valid_nxt  = 1'b0;
          multi_nxt  = 1'b0;
`ifdef PRIO_ENC_TIMEOUT_EN
        end else if (cnt == 8'(TIMEOUT)) begin
          state_nxt  = IDLE;
          ptr_nxt    = o_code;
          onehot_nxt = '0;
          valid_nxt  = 1'b0;
          multi_nxt  = 1'b0;
          to_nxt     = 1'b1;
        end else begin
          cnt_nxt    = cnt + 8'd1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= IDX_W'(N_REQ - 1);
      o_code   <= '0;
      o_onehot <= '0;
      o_valid  <= 1'b0;
      o_multi  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      o_code   <= code_nxt;
      o_onehot <= onehot_nxt;
      o_valid  <= valid_nxt;
      o_multi  <= multi_nxt;
    end
  end

`ifdef PRIO_ENC_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      o_timeout <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      o_timeout <= to_nxt;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prio_encoder_arb_v.sv
// Scoreboard bench for prio_encoder_arb_v: N_REQ=8 (TIMEOUT=4) and N_REQ=5 instances.
module tb_prio_encoder_arb_v;

  typedef struct {
    logic [5:0] code;
    logic       multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] req8 = '0;
  logic       rr8 = 1'b0, rdy8 = 1'b0;
  logic [2:0] code8;
  logic [7:0] oh8;
  logic       v8, m8, to8;

  logic [4:0] req5 = '0;
  logic       rr5 = 1'b0, rdy5 = 1'b0;
  logic [2:0] code5;
  logic [4:0] oh5;
  logic       v5, m5, to5;

  prio_encoder_arb_v #(.N_REQ(8), .TIMEOUT(4)) u8 (
    .i_clk(clk), .i_rst(rst), .i_req(req8), .i_rr_en(rr8),
    .i_ready(rdy8), .o_code(code8), .o_onehot(oh8), .o_valid(v8),
    .o_multi(m8), .o_timeout(to8)
  );

  prio_encoder_arb_v #(.N_REQ(5)) u5 (
    .i_clk(clk), .i_rst(rst), .i_req(req5), .i_rr_en(rr5),
    .i_ready(rdy5), .o_code(code5), .o_onehot(oh5), .o_valid(v5),
    .o_multi(m5), .o_timeout(to5)
  );

  exp_t q8[$];
  exp_t q5[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input int c, input logic m);
    exp_t e;
    e.code = 6'(c);
    e.multi = m;
    q8.push_back(e);
  endtask

  task automatic push5(input int c, input logic m);
    exp_t e;
    e.code = 6'(c);
    e.multi = m;
    q5.push_back(e);
  endtask

  // Monitors: pop on each new grant, then check the grant stays frozen.
  logic       pv8 = 1'b0, pv5 = 1'b0;
  logic [2:0] hc8, hc5;

  always @(negedge clk) begin
    exp_t e;
    if (v8 && !pv8) begin
      n_chk++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL grant8: unexpected code %0d", code8);
      end else begin
        e = q8.pop_front();
        if (code8 !== e.code[2:0] || oh8 !== (8'd1 << e.code) || m8 !== e.multi) begin
          n_fail++;
          $display("FAIL grant8: code %0d oh %h multi %b expected code %0d multi %b",
                   code8, oh8, m8, e.code, e.multi);
        end
      end
      hc8 = code8;
    end else if (v8 && pv8) begin
      n_chk++;
      if (code8 !== hc8 || oh8 !== (8'd1 << hc8)) begin
        n_fail++;
        $display("FAIL hold8: code %0d oh %h expected code %0d", code8, oh8, hc8);
      end
    end
    pv8 = v8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (v5 && !pv5) begin
      n_chk++;
      if (q5.size() == 0) begin
        n_fail++;
        $display("FAIL grant5: unexpected code %0d", code5);
      end else begin
        e = q5.pop_front();
        if (code5 !== e.code[2:0] || oh5 !== (5'd1 << e.code) || m5 !== e.multi) begin
          n_fail++;
          $display("FAIL grant5: code %0d oh %h multi %b expected code %0d multi %b",
                   code5, oh5, m5, e.code, e.multi);
        end
      end
      hc5 = code5;
    end else if (v5 && pv5) begin
      n_chk++;
      if (code5 !== hc5 || oh5 !== (5'd1 << hc5)) begin
        n_fail++;
        $display("FAIL hold5: code %0d oh %h expected code %0d", code5, oh5, hc5);
      end
    end
    pv5 = v5;
  end

  task automatic chk_zero8(input string nm);
    chk({nm, "_code"}, 64'(code8), 64'd0);
    chk({nm, "_onehot"}, 64'(oh8), 64'd0);
    chk({nm, "_valid"}, 64'(v8), 64'd0);
    chk({nm, "_multi"}, 64'(m8), 64'd0);
    chk({nm, "_timeout"}, 64'(to8), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk_zero8("rst");
    chk("rst5_valid", 64'(v5), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk_zero8("idle");

    // Fixed priority: lowest set bit wins
    rr8 = 1'b0;
    req8 = 8'b1010_1100;
    push8(2, 1'b1);
    tick();
    req8 = '0;
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    @(negedge clk);
    chk("fix_bubble_valid", 64'(v8), 64'd0);
    chk("fix_bubble_onehot", 64'(oh8), 64'd0);
    chk("fix_bubble_code", 64'(code8), 64'd2);

    // Round-robin from reset pointer: 0,2,7,0,2
    do_reset();
    rr8 = 1'b1;
    req8 = 8'b1000_0101;
    rdy8 = 1'b1;
    push8(0, 1'b1);
    push8(2, 1'b1);
    push8(7, 1'b1);
    push8(0, 1'b1);
    push8(2, 1'b1);
    repeat (10) tick();
    req8 = '0;
    rdy8 = 1'b0;
    @(negedge clk);
    chk("rr_all_granted", 64'(q8.size()), 64'd0);
    chk("rr_bubble_valid", 64'(v8), 64'd0);

    // N_REQ=5: frozen grant and wrap from 4 to 0
    rr5 = 1'b1;
    req5 = 5'b10000;
    push5(4, 1'b0);
    tick();
    req5 = 5'b00011;
    repeat (3) tick();
    rdy5 = 1'b1;
    tick();
    rdy5 = 1'b0;
    push5(0, 1'b1);
    tick();
    rdy5 = 1'b1;
    tick();
    rdy5 = 1'b0;
    req5 = '0;
    @(negedge clk);
    chk("wrap5_all_granted", 64'(q5.size()), 64'd0);

    // Reset during HOLD drops the grant
    rr8 = 1'b0;
    req8 = 8'h08;
    push8(3, 1'b0);
    tick();
    req8 = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_zero8("rst_hold");
    rr8 = 1'b1;
    req8 = 8'hFF;
    push8(0, 1'b1);
    tick();
    req8 = '0;
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    @(negedge clk);
    chk("rst_hold_granted", 64'(q8.size()), 64'd0);

`ifdef PRIO_ENC_TIMEOUT_EN
    begin
      int k;
      rr8 = 1'b0;
      req8 = 8'h02;
      push8(1, 1'b0);
      tick();
      req8 = '0;
      k = 0;
      @(negedge clk);
      while (!to8 && k < 20) begin
        tick();
        @(negedge clk);
        k++;
      end
      chk("to_seen", 64'(k < 20), 64'd1);
      chk("to_valid", 64'(v8), 64'd0);
      chk("to_onehot", 64'(oh8), 64'd0);
      tick();
      @(negedge clk);
      chk("to_one_cycle", 64'(to8), 64'd0);
      rr8 = 1'b1;
      req8 = 8'h03;
      push8(0, 1'b1);
      tick();
      req8 = '0;
      rdy8 = 1'b1;
      tick();
      rdy8 = 1'b0;
      @(negedge clk);
      chk("to_next_granted", 64'(q8.size()), 64'd0);
    end
`else
    rr8 = 1'b0;
    req8 = 8'h02;
    push8(1, 1'b0);
    tick();
    req8 = '0;
    repeat (20) tick();
    @(negedge clk);
    chk("hold_forever_valid", 64'(v8), 64'd1);
    chk("hold_forever_timeout", 64'(to8), 64'd0);
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    @(negedge clk);
    chk("hold_release_valid", 64'(v8), 64'd0);
`endif

    tick();
    @(negedge clk);
    chk("q8_empty", 64'(q8.size()), 64'd0);
    chk("q5_empty", 64'(q5.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encoder_arb_v.md
Name: prio_encoder_arb_v

Overview:
- Parametrised, registered successor to the 4-line priority encoder. Encodes an N-line request vector into a binary index plus valid.
- Adds selectable round-robin fairness and a valid/ready grant handshake.
- Sits between request sources (e.g. switch/interrupt lines) and a single consumer that accepts one index at a time.

Parameters:
- N_REQ, 8, number of request lines (2..64, power of two not required)
- IDX_W, $clog2(N_REQ), width of index output (derived localparam; never overridden)
- TIMEOUT, 15, HOLD cycles before grant is abandoned (used only with the optional feature; 1..255)

Ports:
- i_clk  input  1  single clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_req  input  N_REQ  request lines; bit k = requester k; level-sensitive
- i_rr_en  input  1  0 = fixed priority (bit 0 highest, legacy order); 1 = round-robin
- i_ready  input  1  consumer accepts current grant
- o_code  output  IDX_W  granted index
- o_onehot  output  N_REQ  one-hot form of o_code; all zero when o_valid=0
- o_valid  output  1  grant present
- o_multi  output  1  more than one i_req bit was set at the arbitration edge
- o_timeout  output  1  one-cycle pulse when a grant is abandoned

Behaviour:
- Reset: o_code=0, o_onehot=0, o_valid=0, o_multi=0, o_timeout=0, state=IDLE, rr pointer ptr=N_REQ-1 (first RR search starts at 0). Reset mid-HOLD drops the grant immediately with no handshake.
- States: IDLE, HOLD.
- IDLE:
  - If i_req==0, stay IDLE with all outputs at their reset values (ptr is not reset).
  - If any i_req bit is set, arbitrate on this edge. Next cycle: o_valid=1, o_code/o_onehot=winner, o_multi=(popcount(i_req)>1); go to HOLD.
  - Latency: request to o_valid is 1 cycle.
- Arbitration:
  - i_rr_en=0: lowest set index wins.
  - i_rr_en=1: first set index searching ptr+1, ptr+2, … with wrap N_REQ-1 -> 0. If only the ptr bit is set, it wins.
  - i_rr_en and i_req are sampled only at the arbitration edge.
- HOLD:
  - o_code, o_onehot, o_valid and o_multi are held stable regardless of i_req changes, including the winner dropping its request.
  - Handshake occurs on the edge where o_valid=1 and i_ready=1. Then ptr<=o_code, go to IDLE; o_valid=0 and o_onehot=0 the next cycle; o_code holds its last value.
- Throughput: one grant per 2 cycles minimum; the bubble cycle is mandatory so a requester can deassert after seeing its grant.
- ptr updates only on a handshake (or timeout, see below). It updates in both modes, so switching to RR continues from the last grant.
- i_ready while o_valid=0 is ignored.
- N_REQ not a power of two: indices >= N_REQ never appear; wrap is at N_REQ-1.

Optional Feature:
- Macro: PRIO_ENC_TIMEOUT_EN.
- Defined:
  - An 8-bit HOLD counter clears on entry to HOLD.
  - When the counter reaches TIMEOUT with no handshake, next cycle: o_valid=0, o_onehot=0, o_timeout=1 for one cycle, ptr<=o_code, state=IDLE.
  - If a handshake coincides with the timeout edge, the handshake wins and no pulse is issued.
- Undefined: no counter; HOLD persists indefinitely; o_timeout is tied to 0.

Test Plan:
- Reset/idle: assert i_rst 2 cycles, i_req=0 -> all outputs 0; release with i_req=0 -> outputs remain 0.
- Fixed priority, N_REQ=8, i_rr_en=0: i_req=8'b1010_1100 -> next cycle o_valid=1, o_code=2, o_onehot=8'h04, o_multi=1; i_ready=1 -> o_valid=0 following cycle.
- Round-robin, i_rr_en=1, i_req held at 8'b1000_0101 with i_ready=1 on every HOLD cycle -> grant sequence 0,2,7,0,2. Each grant is separated by one o_valid=0 cycle.
- Stability/wrap, N_REQ=5: i_req=5'b10000 granted (o_code=4), then i_req changed to 5'b00011 during HOLD -> o_code stays 4 until i_ready; next RR grant is 0.
- Reset mid-HOLD: o_valid=1, o_code=3, i_rst pulse -> next cycle all outputs 0. With i_rr_en=1 and i_req=8'hFF, the next grant is 0.
- With PRIO_ENC_TIMEOUT_EN and TIMEOUT=4: grant index 1, i_ready=0 held -> o_timeout=1 for exactly one cycle, o_valid=0. With i_rr_en=1 and i_req=8'h03, the next grant is 0.
